biriscv_divider_iter: RTL
=========================

Name: biriscv_divider_iter

Overview:
Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU group. It is the inverse-operation companion to the pipelined multiplier. It accepts one divide op from the issue stage on the shared opcode interface and runs a multi-cycle restoring shift-subtract loop. It returns the quotient or remainder with a one-cycle writeback_valid_o pulse; the issue stage stalls on busy_o.

Parameters:
ITER_PER_CYCLE, 1, restoring steps per clock; legal values 1 or 2. Number of iteration cycles N = 32/ITER_PER_CYCLE.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, synchronous, active-low
opcode_valid_i  in  1  issue slot holds a valid op
opcode_opcode_i  in  32  instruction word
opcode_ra_operand_i  in  32  dividend (rs1)
opcode_rb_operand_i  in  32  divisor (rs2)
flush_i  in  1  abort in-flight op
hold_i  in  1  pipeline stall
busy_o  out  1  op in flight; issue must not send another divide
writeback_valid_o  out  1  result valid
writeback_value_o  out  32  quotient or remainder

Behaviour:
- Reset: rst_ni low at a rising edge forces state IDLE, busy_o=0, writeback_valid_o=0, writeback_value_o=0, and clears all datapath registers. This applies in any state, including mid-divide; no result is produced for an aborted op.
- Decode: div_inst = opcode_valid_i and the opcode matches one of the DIV, DIVU, REM, REMU mask/match pairs. is_signed is set for DIV and REM; is_rem is set for REM and REMU.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accepts an op when div_inst=1 and flush_i=0, independent of hold_i. On the accept edge E0 it latches:
    - |dividend| and |divisor|, with magnitudes taken only when is_signed.
    - neg_q = is_signed & (a[31]^b[31]) & (b!=0).
    - neg_r = is_signed & a[31].
    - div_zero = (b==0), the raw dividend, and is_rem.
  - Then goes to BUSY with a step counter of 0.
- BUSY:
  - Each edge performs ITER_PER_CYCLE restoring steps. One step: shift {rem,quot} left by 1; trial = rem - divisor (33-bit); if trial is non-negative, rem=trial and quot[0]=1.
  - After N BUSY edges (E1..EN), the state moves to DONE. hold_i does not pause iteration.
- DONE entry, at edge EN+1:
  - writeback_value_o is registered as follows:
    - div_zero: quotient = 0xFFFFFFFF (both DIV and DIVU); remainder = raw dividend.
    - Otherwise: quotient = neg_q ? -quot : quot; remainder = neg_r ? -rem : rem.
    - The output is the remainder when is_rem, else the quotient.
  - Overflow case (0x80000000 / -1) falls out naturally: quotient 0x80000000, remainder 0. It needs no special path.
  - writeback_valid_o=1 from EN+1.
- DONE:
  - If hold_i=0, the next edge returns to IDLE and writeback_valid_o drops, giving a one-cycle pulse.
  - If hold_i=1, the state remains DONE and writeback_valid_o/value are held stable until the first edge with hold_i=0.
- Latency: accept edge E0 to valid visible is N+1 edges, i.e. 33 for ITER_PER_CYCLE=1 and 17 for 2.
- busy_o = (state != IDLE). It is registered, and is high from the cycle after E0 through the last DONE cycle.
- Back-to-back: the next op is accepted only in IDLE, so the minimum issue spacing is N+2 cycles.
- Flush:
  - flush_i=1 in BUSY returns the block to IDLE at the next edge with no valid pulse.
  - flush_i=1 in DONE drops writeback_valid_o at the next edge.
  - flush_i=1 in IDLE blocks the accept.
  - flush_i has priority over hold_i.
- writeback_value_o holds its last value while idle. Consumers qualify it with writeback_valid_o.
- Non-divide opcodes are ignored in every state.

Decomposition:
- The DIV/DIVU/REM/REMU mask/match constants come from the existing shared defs include; no new package is needed.
- State encoding localparams are local to the block.
- One natural sub-module, biriscv_div_step: a combinational single restoring step, with inputs rem[31:0], quot[31:0], divisor[31:0] and outputs rem_next/quot_next. It is instantiated ITER_PER_CYCLE times in a chain.

Test Plan:
- DIV 20 / -3 (0x00000014, 0xFFFFFFFD) -> value 0xFFFFFFFA; valid 33 edges after accept; busy_o high throughout. REM of the same operands -> 0x00000002.
- DIVU 0xFFFFFFFF / 0 -> 0xFFFFFFFF. DIV -7 / 0 -> 0xFFFFFFFF. REM -7 / 0 -> 0xFFFFFFF9. REMU 7 / 0 -> 0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0x00000000. DIVU 0x80000000 / 2 -> 0x40000000.
- hold_i=1 for 3 cycles starting at DONE -> writeback_valid_o high for 4 cycles with a stable value, then IDLE. A second op issued during BUSY is not accepted; the bench checks it is ignored.
- flush_i pulse at BUSY step 10 -> no valid pulse; busy_o low next cycle; a new DIVU 100/7 accepted afterwards -> 0x0000000E.
- rst_ni low mid-BUSY -> all outputs 0 next cycle, no valid. Repeat the first scenario with ITER_PER_CYCLE=2 -> same results at a latency of 17 edges.

Source files
------------

// File: rtl/biriscv_divider_iter_pkg.sv
// rtl/biriscv_divider_iter_pkg.sv - RV32M divide opcode mask/match constants and decode helper
package biriscv_divider_iter_pkg;

  localparam logic [31:0] INST_DIV_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_DIV      = 32'h02004033;
  localparam logic [31:0] INST_DIVU     = 32'h02005033;
  localparam logic [31:0] INST_REM      = 32'h02006033;
  localparam logic [31:0] INST_REMU     = 32'h02007033;

  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic is_rem;
  } div_decode_t;

  function automatic div_decode_t div_decode(input logic [31:0] op);
    div_decode_t d;
    logic [31:0] m;
    m           = op & INST_DIV_MASK;
    d.is_div    = (m == INST_DIV) || (m == INST_DIVU) || (m == INST_REM) || (m == INST_REMU);
    d.is_signed = (m == INST_DIV) || (m == INST_REM);
    d.is_rem    = (m == INST_REM) || (m == INST_REMU);
    return d;
  endfunction

endpackage

// File: rtl/biriscv_div_step.sv
// rtl/biriscv_div_step.sv - one combinational restoring shift-subtract step
module biriscv_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] shifted;
  logic        fits;

  // rem < divisor on entry, so the shifted remainder fits in 33 bits and the
  // restored/subtracted result always fits back in 32
  assign shifted   = {rem, quot[31]};
  assign fits      = (shifted >= {1'b0, divisor});
  assign rem_next  = fits ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
  assign quot_next = {quot[30:0], fits};

endmodule

// File: rtl/biriscv_divider_iter.sv
// rtl/biriscv_divider_iter.sv - iterative RV32M DIV/DIVU/REM/REMU unit
module biriscv_divider_iter
  import biriscv_divider_iter_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o
);

  localparam int          N_ITER = 32 / ITER_PER_CYCLE;
  localparam logic [5:0]  N_LAST = 6'(N_ITER);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_next;
  logic [5:0]  count_q;
  logic [31:0] rem_q, quot_q, divisor_q, dividend_raw_q;
  logic        neg_q_q, neg_r_q, div_zero_q, is_rem_q;
  logic        busy_q, wb_valid_q;
  logic [31:0] wb_value_q;

  div_decode_t dec;
  logic        accept;
  logic [31:0] a_abs, b_abs;
  logic [31:0] q_res, r_res;

  assign dec    = div_decode(opcode_opcode_i);
  assign accept = opcode_valid_i && dec.is_div && !flush_i;
  assign a_abs  = (dec.is_signed && opcode_ra_operand_i[31]) ? -opcode_ra_operand_i : opcode_ra_operand_i;
  assign b_abs  = (dec.is_signed && opcode_rb_operand_i[31]) ? -opcode_rb_operand_i : opcode_rb_operand_i;

  logic [31:0] rem_c  [ITER_PER_CYCLE+1];
  logic [31:0] quot_c [ITER_PER_CYCLE+1];

  assign rem_c[0]  = rem_q;
  assign quot_c[0] = quot_q;

  for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
    biriscv_div_step u_step (
      .rem       (rem_c[i]),
      .quot      (quot_c[i]),
      .divisor   (divisor_q),
      .rem_next  (rem_c[i+1]),
      .quot_next (quot_c[i+1])
    );
  end

  // Divide-by-zero results are fixed by the ISA; overflow needs no special case
  assign q_res = div_zero_q ? 32'hffff_ffff : (neg_q_q ? -quot_q : quot_q);
  assign r_res = div_zero_q ? dividend_raw_q : (neg_r_q ? -rem_q : rem_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: begin
        if (flush_i)               state_next = ST_IDLE;
        else if (count_q == N_LAST) state_next = ST_DONE;
      end
      ST_DONE: if (flush_i || !hold_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q        <= '0;
      rem_q          <= '0;
      quot_q         <= '0;
      divisor_q      <= '0;
      dividend_raw_q <= '0;
      neg_q_q        <= 1'b0;
      neg_r_q        <= 1'b0;
      div_zero_q     <= 1'b0;
      is_rem_q       <= 1'b0;
      busy_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_value_q     <= '0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_q          <= '0;
            quot_q         <= a_abs;
            divisor_q      <= b_abs;
            dividend_raw_q <= opcode_ra_operand_i;
            neg_q_q        <= dec.is_signed && (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31])
                              && (opcode_rb_operand_i != 32'd0);
            neg_r_q        <= dec.is_signed && opcode_ra_operand_i[31];
            div_zero_q     <= (opcode_rb_operand_i == 32'd0);
            is_rem_q       <= dec.is_rem;
            count_q        <= '0;
          end
        end
        ST_BUSY: begin
          if (!flush_i) begin
            if (count_q == N_LAST) begin
              wb_valid_q <= 1'b1;
              wb_value_q <= is_rem_q ? r_res : q_res;
            end else begin
              rem_q   <= rem_c[ITER_PER_CYCLE];
              quot_q  <= quot_c[ITER_PER_CYCLE];
              count_q <= count_q + 6'd1;
            end
          end
        end
        ST_DONE: if (flush_i || !hold_i) wb_valid_q <= 1'b0;
        default: wb_valid_q <= 1'b0;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign writeback_valid_o = wb_valid_q;
  assign writeback_value_o = wb_value_q;

endmodule
